// File: rtl/arith_pkg.sv
// Shared types and constants for the arithmetic command sequencer slice.
package arith_pkg;

    // Default operand/result width shared with the arithmetic unit.
    localparam int BITS_DEF = 32;

    // Operation codes understood by the arithmetic unit.
    typedef enum logic [1:0] {
        OP_CONV  = 2'b00,
        OP_CMP   = 2'b01,
        OP_SET   = 2'b10,
        OP_SHIFT = 2'b11
    } op_t;

    // Bit positions inside the 4-bit status word {ERROR, ODD_ZEROS, ZEROS, OVERFLOW}.
    localparam int ST_OVERFLOW  = 0;
    localparam int ST_ZEROS     = 1;
    localparam int ST_ODD_ZEROS = 2;
    localparam int ST_ERROR     = 3;

    // Sequencer states: one cycle each, except RESP which waits for the consumer.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_CAPT = 2'b10,
        S_RESP = 2'b11
    } seq_state_t;

    // True when a status word carries the ERROR flag.
    function automatic logic is_error(input logic [3:0] status);
        return status[ST_ERROR];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on i_inc and sticks at its all-ones value.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    // Next value of the counter, clamped at the top of its range.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] value);
        return (value == CNT_MAX) ? value : value + WIDTH'(1);
    endfunction

    // Count register, cleared by the asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_count <= '0;
        end else if (i_inc) begin
            o_count <= sat_inc(o_count);
        end
    end

endmodule

// File: rtl/arith_cmd_sequencer.sv
// Command sequencer in front of a registered arithmetic unit.
// A command is latched onto the unit's operand bus, the registered result is
// captured two cycles later and held as a response until the consumer takes it.
module arith_cmd_sequencer
    import arith_pkg::*;
#(
    parameter int BITS  = BITS_DEF,
    parameter int ERR_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic signed [BITS-1:0] i_cmd_A,
    input  logic signed [BITS-1:0] i_cmd_B,
    input  logic [1:0]             i_cmd_op,
    output logic signed [BITS-1:0] o_alu_arg_A,
    output logic signed [BITS-1:0] o_alu_arg_B,
    output logic [1:0]             o_alu_op,
    input  logic signed [BITS-1:0] i_alu_result,
    input  logic [3:0]             i_alu_status,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic signed [BITS-1:0] o_rsp_result,
    output logic [3:0]             o_rsp_status,
    output logic [1:0]             o_rsp_op,
    output logic [15:0]            o_cmd_count,
    output logic [ERR_W-1:0]       o_err_count
);

    seq_state_t             state_q;
    seq_state_t             state_d;
    logic                   accept;
    logic                   capt_en;
    logic                   rsp_hs;
    logic                   err_inc;

    logic signed [BITS-1:0] alu_a_p0;
    logic signed [BITS-1:0] alu_b_p0;
    op_t                    alu_op_p0;
    logic signed [BITS-1:0] rsp_result_p2;
    logic [3:0]             rsp_status_p2;
    op_t                    rsp_op_p2;
    logic [15:0]            cmd_count_q;

    // State register; reset drops any command or response in flight.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed walk IDLE->EXEC->CAPT->RESP, RESP waits for ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_cmd_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_CAPT;
            S_CAPT:  state_d = S_RESP;
            S_RESP:  if (i_rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded handshakes and strobes; none depend on the unit's outputs.
    always_comb begin
        o_cmd_ready = (state_q == S_IDLE);
        o_rsp_valid = (state_q == S_RESP);
        accept      = o_cmd_ready & i_cmd_valid;
        capt_en     = (state_q == S_CAPT);
        rsp_hs      = o_rsp_valid & i_rsp_ready;
    end

    // Stage 0: operands and op held on the unit's bus from accept to next accept.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            alu_a_p0  <= '0;
            alu_b_p0  <= '0;
            alu_op_p0 <= OP_CONV;
        end else if (accept) begin
            alu_a_p0  <= i_cmd_A;
            alu_b_p0  <= i_cmd_B;
            alu_op_p0 <= op_t'(i_cmd_op);
        end
    end

    // Stage 2: capture the unit's registered result one cycle after it settles.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rsp_result_p2 <= '0;
            rsp_status_p2 <= '0;
            rsp_op_p2     <= OP_CONV;
        end else if (capt_en) begin
            rsp_result_p2 <= i_alu_result;
            rsp_status_p2 <= i_alu_status;
            rsp_op_p2     <= alu_op_p0;
        end
    end

    // Completed-command counter, wraps naturally at 16 bits.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cmd_count_q <= '0;
        end else if (rsp_hs) begin
            cmd_count_q <= cmd_count_q + 16'd1;
        end
    end

    assign err_inc = rsp_hs & is_error(rsp_status_p2);

    sat_counter #(
        .WIDTH (ERR_W)
    ) u_err_count (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (err_inc),
        .o_count (o_err_count)
    );

    assign o_alu_arg_A  = alu_a_p0;
    assign o_alu_arg_B  = alu_b_p0;
    assign o_alu_op     = alu_op_p0;
    assign o_rsp_result = rsp_result_p2;
    assign o_rsp_status = rsp_status_p2;
    assign o_rsp_op     = rsp_op_p2;
    assign o_cmd_count  = cmd_count_q;

endmodule
